uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data bits per frame (5..9).
REQ-002 SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bit count (1 or 2).
REQ-004 SHALL have port clk  input  1  system clock; all state on posedge clk.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port baud_in  input  1  divided baud clock from the clock divider; asynchronous to frame logic.
REQ-007 SHALL have port tx_data  input  DATA_W  byte to send, LSB first.
REQ-008 SHALL have port tx_valid  input  1  tx_data is valid.
REQ-009 SHALL have port tx_ready  output  1  block can accept a byte.
REQ-010 SHALL have port tx  output  1  serial line, idle high, registered.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-012 SHALL pass baud_in through a 2-flop synchroniser, then detect rising edges, giving baud_tick: exactly one clk-cycle pulse per baud_in rising edge.
REQ-013 SHALL have states IDLE, ALIGN, START, DATA, PAR, STOP.
REQ-014 SHALL drive tx_ready = 1 only in IDLE; busy = not IDLE.
REQ-015 SHALL accept a byte when tx_valid && tx_ready: latch tx_data into a shift register and enter ALIGN on the next edge.
REQ-016 SHALL ignore tx_valid outside IDLE; tx_data changes after acceptance SHALL NOT affect the frame.
REQ-017 SHALL hold tx = 1 in ALIGN; on baud_tick go to START, driving tx = 0.
REQ-018 SHALL change state and tx only on baud_tick in START/DATA/PAR/STOP, so every bit lasts exactly one baud_tick interval.
REQ-019 SHALL go START -> DATA on baud_tick, driving bit 0 of the latched byte.
REQ-020 SHALL, in DATA, shift out bit i+1 on each baud_tick; after bit DATA_W-1 go to PAR if PARITY != 0, else STOP.
REQ-021 SHALL drive PAR as the XOR of the data bits for PARITY = 1, and its inverse for PARITY = 2.
REQ-022 SHALL drive tx = 1 in STOP for STOP_BITS baud_tick intervals, then return to IDLE on the final baud_tick.
REQ-023 SHALL accept a byte in the first IDLE cycle if tx_valid is already high, allowing back-to-back frames with one ALIGN interval between them.
REQ-024 SHALL use a bit counter of width clog2(DATA_W+1), with no wrap beyond DATA_W.
REQ-025 SHALL give baud_tick no effect in IDLE.

Reset
REQ-026 SHALL, on reset assertion, immediately set state IDLE, tx = 1, busy = 0, tx_ready = 1, shift register = 0, bit counter = 0, and synchroniser/edge flops = 0.
REQ-027 SHALL abandon a frame in progress when reset asserts mid-frame, with tx returning high at once and no partial resumption.
REQ-028 SHALL treat a first synchronised baud_in high after reset as a rising edge; this is harmless because IDLE ignores it.

Structure
REQ-029 SHALL take the state enum and parity constants (PAR_NONE, PAR_EVEN, PAR_ODD) from shared package uart_pkg.
REQ-030 SHALL instantiate one sub-module, sync_rise, containing the 2-flop synchroniser and rising-edge detector, for reuse by the future uart_rx.

Verification
REQ-031 SHALL cover: defaults, baud_in from divider N=6 (24-clk period), send 0x55 -> tx: 1 (align), 0, 1,0,1,0,1,0,1,0, 1; each bit 24 clk.
REQ-032 SHALL cover: PARITY=1, send 0x07 -> parity bit 1; PARITY=2, send 0x07 -> parity bit 0.
REQ-033 SHALL cover: STOP_BITS=2, tx_valid held high with 0xA3 then 0x3C -> two frames, 2 stop intervals each, tx_ready high exactly one cycle between them.
REQ-034 SHALL cover: reset pulsed during data bit 3 of 0xFF -> tx = 1 and tx_ready = 1 in the same cycle; the next byte 0x01 is sent cleanly.
REQ-035 SHALL cover: tx_data changed to 0x00 one cycle after accepting 0xF0 -> line still shows 0xF0.
REQ-036 SHALL cover: baud_in held static for 1000 clk mid-frame -> tx and state frozen, no spurious ticks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and parity modes.
// The future uart_rx imports this package as well.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Parity bit to transmit, given the XOR of all data bits.
  function automatic logic parity_bit(input logic data_xor, input int mode);
    case (mode)
      PAR_EVEN: parity_bit = data_xor;
      PAR_ODD:  parity_bit = ~data_xor;
      default:  parity_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchroniser for an asynchronous level, followed by a
// rising-edge detector producing a single clk-cycle pulse per edge.
module sync_rise (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  // prev_reg starts low, so a level already high after reset reads as an edge.
  assign rise = sync_reg & ~prev_reg;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a word on a valid/ready handshake and shifts it
// out LSB first, one bit per rising edge of the externally divided baud clock.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud_in,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy
);

  localparam int   CNT_W     = $clog2(DATA_W + 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  tx_state_t         state_reg, state_next;
  logic              tx_reg, tx_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic              stop_cnt_reg, stop_cnt_next;
  logic              par_reg, par_next;
  logic              baud_tick;

  sync_rise u_sync_rise (
    .clk   (clk),
    .reset (reset),
    .din   (baud_in),
    .rise  (baud_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      tx_reg       <= 1'b1;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      par_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tx_reg       <= tx_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      par_reg      <= par_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tx_next       = tx_reg;
    shift_next    = shift_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    par_next      = par_reg;

    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (tx_valid) begin
          // Parity is fixed at acceptance, since the shift register drains.
          shift_next    = tx_data;
          par_next      = parity_bit(^tx_data, PARITY);
          bit_cnt_next  = '0;
          stop_cnt_next = 1'b0;
          state_next    = ALIGN;
        end
      end
      ALIGN: begin
        if (baud_tick) begin
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (baud_tick) begin
          tx_next      = shift_reg[0];
          shift_next   = shift_reg >> 1;
          bit_cnt_next = CNT_W'(1);
          state_next   = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt_reg == CNT_W'(DATA_W)) begin
            if (PARITY != PAR_NONE) begin
              tx_next    = par_reg;
              state_next = PAR;
            end else begin
              tx_next    = 1'b1;
              state_next = STOP;
            end
          end else begin
            tx_next      = shift_reg[0];
            shift_next   = shift_reg >> 1;
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end
      end
      PAR: begin
        if (baud_tick) begin
          tx_next    = 1'b1;
          state_next = STOP;
        end
      end
      STOP: begin
        if (baud_tick) begin
          if (stop_cnt_reg == STOP_LAST) begin
            state_next = IDLE;
          end else begin
            stop_cnt_next = 1'b1;
          end
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  assign tx       = tx_reg;
  assign tx_ready = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances (default, even parity, odd parity,
// two stop bits) sharing one clock and a 24-clk-period baud clock.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_in = 1'b0;
  logic       baud_run = 1'b1;
  int         baud_cnt = 0;
  logic [7:0] tx_data_a [4];
  logic [3:0] tx_valid_a = '0;
  logic [3:0] tx_ready_a;
  logic [3:0] busy_a;
  logic [3:0] tx_a;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int cyc       = 0;
  int ready_cnt = 0;
  bit ready_cnt_en = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: baud_in toggles every 12 clk, i.e. a 24-clk period.
  always @(negedge clk) begin
    if (baud_run) begin
      if (baud_cnt == 11) begin
        baud_cnt <= 0;
        baud_in  <= ~baud_in;
      end else begin
        baud_cnt <= baud_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (ready_cnt_en && tx_ready_a[3]) ready_cnt <= ready_cnt + 1;
  end

  uart_tx u_dut0 (
    .clk(clk), .reset(reset), .baud_in(baud_in), .tx_data(tx_data_a[0]),
    .tx_valid(tx_valid_a[0]), .tx_ready(tx_ready_a[0]), .tx(tx_a[0]), .busy(busy_a[0])
  );

  uart_tx #(.PARITY(1)) u_even (
    .clk(clk), .reset(reset), .baud_in(baud_in), .tx_data(tx_data_a[1]),
    .tx_valid(tx_valid_a[1]), .tx_ready(tx_ready_a[1]), .tx(tx_a[1]), .busy(busy_a[1])
  );

  uart_tx #(.PARITY(2)) u_odd (
    .clk(clk), .reset(reset), .baud_in(baud_in), .tx_data(tx_data_a[2]),
    .tx_valid(tx_valid_a[2]), .tx_ready(tx_ready_a[2]), .tx(tx_a[2]), .busy(busy_a[2])
  );

  uart_tx #(.STOP_BITS(2)) u_stop2 (
    .clk(clk), .reset(reset), .baud_in(baud_in), .tx_data(tx_data_a[3]),
    .tx_valid(tx_valid_a[3]), .tx_ready(tx_ready_a[3]), .tx(tx_a[3]), .busy(busy_a[3])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send(input int sel, input logic [7:0] d);
    @(negedge clk);
    tx_data_a[sel]  = d;
    tx_valid_a[sel] = 1'b1;
    @(negedge clk);
    tx_valid_a[sel] = 1'b0;
    $display("send dut%0d data=0x%02h", sel, d);
  endtask

  task automatic wait_start(input int sel, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_a[sel] == 1'b0) begin
        seen = 1;
        break;
      end
    end
    check_eq(tag, seen, 1);
  endtask

  // Called at the middle of a bit; samples the middle of the next n bits.
  task automatic sample_bits(input int sel, input int n, output logic [15:0] v);
    v = '0;
    for (int i = 0; i < n; i++) begin
      repeat (24) @(negedge clk);
      v[i] = tx_a[sel];
    end
  endtask

  task automatic wait_idle(input int sel, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_ready_a[sel]) begin
        seen = 1;
        break;
      end
    end
    check_eq(tag, seen, 1);
  endtask

  task automatic capture(input int sel, input int n, input string tag, output logic [15:0] v);
    wait_start(sel, {tag, "_start"});
    repeat (12) @(negedge clk);
    check_eq({tag, "_startbit"}, tx_a[sel], 1'b0);
    sample_bits(sel, n, v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    int len, t1, t2, low_cnt, nready_cnt, changes;
    logic prev;

    for (int i = 0; i < 4; i++) tx_data_a[i] = 8'h00;

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx_a[0], 1'b1);
    check_eq("rst_ready", tx_ready_a[0], 1'b1);
    check_eq("rst_busy", busy_a[0], 1'b0);
    check_eq("rst_tx_all", tx_a, 4'hF);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 0x55: every segment alternates, so each bit length is measurable
    send(0, 8'h55);
    check_eq("t55_align_tx", tx_a[0], 1'b1);
    check_eq("t55_align_busy", busy_a[0], 1'b1);
    check_eq("t55_align_ready", tx_ready_a[0], 1'b0);
    wait_start(0, "t55_start");
    for (int seg = 0; seg < 9; seg++) begin
      len = 0;
      while (tx_a[0] == 1'(seg % 2) && len < 40) begin
        len++;
        @(negedge clk);
      end
      check_eq($sformatf("t55_len%0d", seg), len, 24);
    end
    check_eq("t55_stop", tx_a[0], 1'b1);
    wait_idle(0, "t55_idle");
    check_eq("t55_idle_tx", tx_a[0], 1'b1);

    // Parity: 0x07 has three ones
    send(1, 8'h07);
    capture(1, 10, "even", v);
    check_eq("even_data", v[7:0], 8'h07);
    check_eq("even_par", v[8], 1'b1);
    check_eq("even_stop", v[9], 1'b1);
    wait_idle(1, "even_idle");

    send(2, 8'h07);
    capture(2, 10, "odd", v);
    check_eq("odd_data", v[7:0], 8'h07);
    check_eq("odd_par", v[8], 1'b0);
    check_eq("odd_stop", v[9], 1'b1);
    wait_idle(2, "odd_idle");

    // Two stop bits, tx_valid held high across back-to-back frames
    @(negedge clk);
    tx_data_a[3]  = 8'hA3;
    tx_valid_a[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!tx_ready_a[3]) break;
    end
    check_eq("b2b_accept1", tx_ready_a[3], 1'b0);
    tx_data_a[3] = 8'h3C;
    ready_cnt_en = 1'b1;
    $display("send dut3 data=0xa3 (valid held)");
    wait_start(3, "b2b_start1");
    t1 = cyc;
    repeat (12) @(negedge clk);
    sample_bits(3, 10, v);
    check_eq("b2b_data1", v[7:0], 8'hA3);
    check_eq("b2b_stops1", v[9:8], 2'b11);
    wait_start(3, "b2b_start2");
    t2 = cyc;
    tx_valid_a[3] = 1'b0;
    ready_cnt_en  = 1'b0;
    $display("send dut3 data=0x3c (valid held)");
    check_eq("b2b_gap", t2 - t1, 288);
    check_eq("b2b_ready_cycles", ready_cnt, 1);
    repeat (12) @(negedge clk);
    sample_bits(3, 10, v);
    check_eq("b2b_data2", v[7:0], 8'h3C);
    check_eq("b2b_stops2", v[9:8], 2'b11);
    wait_idle(3, "b2b_idle");

    // Reset during data bit 3 of 0xFF
    send(0, 8'hFF);
    wait_start(0, "rst_mid_start");
    repeat (108) @(negedge clk);
    check_eq("rst_mid_busy_before", busy_a[0], 1'b1);
    reset = 1'b1;
    #1;
    check_eq("rst_mid_tx", tx_a[0], 1'b1);
    check_eq("rst_mid_ready", tx_ready_a[0], 1'b1);
    check_eq("rst_mid_busy", busy_a[0], 1'b0);
    @(negedge clk);
    reset = 1'b0;
    low_cnt = 0;
    nready_cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (!tx_a[0]) low_cnt++;
      if (!tx_ready_a[0]) nready_cnt++;
    end
    check_eq("rst_no_resume_tx", low_cnt, 0);
    check_eq("rst_no_resume_ready", nready_cnt, 0);
    send(0, 8'h01);
    capture(0, 9, "after_rst", v);
    check_eq("after_rst_data", v[7:0], 8'h01);
    check_eq("after_rst_stop", v[8], 1'b1);
    wait_idle(0, "after_rst_idle");

    // tx_data changed right after acceptance
    @(negedge clk);
    tx_data_a[0]  = 8'hF0;
    tx_valid_a[0] = 1'b1;
    @(negedge clk);
    tx_valid_a[0] = 1'b0;
    tx_data_a[0]  = 8'h00;
    $display("send dut0 data=0xf0 (data cleared next cycle)");
    capture(0, 9, "latch", v);
    check_eq("latch_data", v[7:0], 8'hF0);
    check_eq("latch_stop", v[8], 1'b1);
    wait_idle(0, "latch_idle");

    // Baud clock frozen for 1000 clk during bit 2 of 0x96
    send(0, 8'h96);
    wait_start(0, "freeze_start");
    repeat (84) @(negedge clk);
    check_eq("freeze_bit2", tx_a[0], 1'b1);
    baud_run = 1'b0;
    changes = 0;
    prev = tx_a[0];
    repeat (1000) begin
      @(negedge clk);
      if (tx_a[0] != prev) changes++;
      prev = tx_a[0];
    end
    check_eq("freeze_changes", changes, 0);
    check_eq("freeze_tx", tx_a[0], 1'b1);
    check_eq("freeze_busy", busy_a[0], 1'b1);
    baud_run = 1'b1;
    sample_bits(0, 6, v);
    check_eq("freeze_rest", v[5:0], 6'b110010);
    wait_idle(0, "freeze_idle");

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
